picomips_input_port: RTL
========================

# picomips_input_port

Switch/button front-end feeding the picoMIPS CPU's `x` data input and `Bstus` branch-status input. Synchronises raw board switches and a push button into `clk`, debounces the button with a four-state FSM, and presents a stable data word and a clean status level. CPU programs poll `Bstus` and fetch `x` once it is high. The block sits between the board pins and the CPU top level.

## Interface
Parameters:
- `n`, 8: data width; matches CPU data bus.
- `DB_CYCLES`, 16: consecutive stable samples required to accept a button change; legal range 1..65535.
- `CNT_W`, `$clog2(DB_CYCLES+1)`: debounce counter width; derived, not overridden.

Ports:
- `clk`  in  1: system clock.
- `nreset`  in  1: asynchronous, active-low reset.
- `sw`  in  n: raw asynchronous switch inputs.
- `btn`  in  1: raw asynchronous push button, active-high, may bounce.
- `x`  out  n: data word to CPU; registered.
- `Bstus`  out  1: debounced button level to CPU; registered.
- `presses`  out  8: count of accepted presses; registered, wraps.

## Operation
- Synchronisers: two flops each on `sw` (all n bits) and `btn`, giving `sw_s` and `btn_s`.
- FSM states: IDLE (released), PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: `btn_s`=1 -> PRESS_WAIT with `cnt`=1, unless DB_CYCLES=1, which goes directly to HELD (accept).
  - PRESS_WAIT: `btn_s`=0 -> IDLE, `cnt`=0. `btn_s`=1 and `cnt`=DB_CYCLES-1 -> HELD (accept press). Otherwise `cnt`++.
  - HELD: `btn_s`=0 -> RELEASE_WAIT with `cnt`=1; for DB_CYCLES=1, go directly to IDLE.
  - RELEASE_WAIT: `btn_s`=1 -> HELD, `cnt`=0. `btn_s`=0 and `cnt`=DB_CYCLES-1 -> IDLE (accept release). Otherwise `cnt`++.
- Accept press, on the same edge:
  - `Bstus`<=1.
  - `x`<=`sw_s`.
  - `presses`<=`presses`+1, modulo 256; 255 wraps to 0.
- Accept release: `Bstus`<=0. `x` and `presses` unchanged.
- `Bstus` is 1 exactly in HELD and RELEASE_WAIT. A bounce during RELEASE_WAIT does not drop `Bstus`.
- `cnt` never exceeds DB_CYCLES-1. It is cleared on every state change.

## Timing
- Reset (asynchronous assert):
  - `x`=0, `Bstus`=0, `presses`=0.
  - FSM=IDLE, `cnt`=0, all synchroniser flops 0.
- Release of `nreset` is synchronous to `clk`. The first FSM evaluation occurs on the first rising edge after deassertion.
- Press latency: `btn` rising before edge k, then held, gives `Bstus`=1 after edge k+1+DB_CYCLES. `x`, `Bstus` and `presses` update on the same edge.
- Release latency: symmetric, `Bstus`=0 after edge k+1+DB_CYCLES.
- Bounce rule: any `btn_s` pulse shorter than DB_CYCLES cycles produces no output change.
- Reset mid-debounce: the FSM returns to IDLE immediately and partial counts are discarded.
- `sw` is sampled only via `sw_s`, i.e. the value 2 edges old at the accept edge.

## Configuration
- `PICOMIPS_IN_HOLD_EN`
  - Defined: `x` is loaded only at accept press and holds while switches move. This is the behaviour described in Operation.
  - Undefined: `x`<=`sw_s` every cycle, regardless of FSM state. `Bstus` and `presses` behave identically in both builds.

## Test plan
- Reset: with `nreset`=0, drive `sw`=8'hFF, `btn`=1 -> `x`=0, `Bstus`=0, `presses`=0 throughout.
- Clean press, DB_CYCLES=4, HOLD_EN defined:
  - Stimulus: `sw`=8'h5A, `btn` rises before edge 10.
  - Required: `Bstus`=1, `x`=8'h5A, `presses`=1 after edge 15, not before.
- Bounce, DB_CYCLES=4: `btn` pulses high for 3 cycles, low for 2, repeated 5 times, then held low -> `Bstus` stays 0, `presses` stays 0.
- Switch change while held, HOLD_EN defined:
  - Stimulus: after the press above, `sw` changes to 8'hC3.
  - Required: `x` stays 8'h5A.
  - Same stimulus with HOLD_EN undefined: `x`=8'hC3 two edges after the change.
- Release glitch, DB_CYCLES=4:
  - Stimulus: in HELD, `btn` low for 2 cycles then high, later low for 6 cycles.
  - Required: `Bstus` stays 1 through the glitch, then falls after the 4th stable-low `btn_s` sample.
- Reset mid-PRESS_WAIT followed by 256 clean presses:
  - After reset: `presses`=0, `Bstus`=0.
  - After the presses: `presses` wraps 255->0 on the 256th accept.

Source files
------------

// File: rtl/picomips_input_port.sv
// -----------------------------------------------------------------------------
// picomips_input_port
//
// Board-side input front-end for the picoMIPS CPU. Raw switches and a push
// button are brought into the clk domain through two-flop synchronisers. The
// button is then debounced by a four-state FSM. The CPU polls Bstus and reads x
// once Bstus is high.
//
// Parameters:
//   n          data width (CPU data bus width)
//   DB_CYCLES  consecutive stable synchronised samples needed to accept a
//              button change (1..65535)
//   CNT_W      debounce counter width, derived from DB_CYCLES
//
// Ports:
//   clk        system clock
//   nreset     asynchronous active-low reset
//   sw[n]      raw asynchronous switches
//   btn        raw asynchronous push button, active-high, may bounce
//   x[n]       data word to CPU (registered)
//   Bstus      debounced button level to CPU (registered)
//   presses[8] count of accepted presses, wraps 255 -> 0 (registered)
//   state_dbg  current debounce FSM state (IDLE=0, PRESS_WAIT=1, HELD=2,
//              RELEASE_WAIT=3)
//
// Build option:
//   PICOMIPS_IN_HOLD_EN  defined: x is captured from the synchronised
//                        switches only on an accepted press and holds
//                        afterwards. Undefined: x follows the synchronised
//                        switches every cycle. Bstus and presses behave the
//                        same in both builds.
//
// Handshake: there is no valid/ready pair. Bstus acts as a level-valid for x:
// in the hold build x is stable for as long as Bstus stays high, and the CPU
// has no back-pressure to apply.
// -----------------------------------------------------------------------------
module picomips_input_port #(
  parameter int n         = 8,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [n-1:0] sw,
  input  logic         btn,
  output logic [n-1:0] x,
  output logic         Bstus,
  output logic [7:0]   presses,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // With a single required sample, an edge seen on btn_s is accepted at once.
  localparam bit DB_ONE = (DB_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [n-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic         btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [n-1:0] sw_s;
  logic         btn_s;

  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
    end
  end

  assign sw_s  = sw_sync_q;
  assign btn_s = btn_sync_q;

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_press;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state
  // cnt holds the number of consecutive samples already seen at the new level,
  // so the sample that arrives while cnt == DB_CYCLES-1 is the accepting one.
  // Every state change clears or restarts cnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          if (DB_ONE) begin
            state_d      = HELD;
            cnt_d        = '0;
            accept_press = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = HELD;
          cnt_d        = '0;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          if (DB_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: outputs (registered)
  // Bstus mirrors "next state is HELD or RELEASE_WAIT", so it rises on the
  // accept-press edge, falls on the accept-release edge and ignores bounces
  // inside RELEASE_WAIT.
  // ---------------------------------------------------------------------------
  logic [n-1:0] x_q, x_d;
  logic         bstus_q, bstus_d;
  logic [7:0]   presses_q, presses_d;

  always_comb begin
    bstus_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
    presses_d = accept_press ? presses_q + 8'd1 : presses_q;
`ifdef PICOMIPS_IN_HOLD_EN
    x_d       = accept_press ? sw_s : x_q;
`else
    x_d       = sw_s;
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_q       <= '0;
      bstus_q   <= 1'b0;
      presses_q <= 8'd0;
    end else begin
      x_q       <= x_d;
      bstus_q   <= bstus_d;
      presses_q <= presses_d;
    end
  end

  assign x         = x_q;
  assign Bstus     = bstus_q;
  assign presses   = presses_q;
  assign state_dbg = state_q;

endmodule
